// File: rtl/mult_div_unit_pkg.sv
// Shared types and defaults for the multiply/divide unit and its result calculator.
package mult_div_unit_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef logic [WORD_W-1:0] int_t;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } mdu_operation_t;

  typedef struct packed {
    int_t hi;
    int_t lo;
  } mdu_result_t;

endpackage

// File: rtl/mult_div_unit_result_calc.sv
// Combinational HI/LO result for multiply/divide operations, including the
// signed-division, overflow and divide-by-zero corner cases.
module mult_div_unit_result_calc
  import mult_div_unit_pkg::*;
(
  input  int_t           operand1,
  input  int_t           operand2,
  input  mdu_operation_t operation,
  output mdu_result_t    result_c,
  output logic           writes_result_c,
  output logic           div_by_zero_c
);

  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic               neg1;
  logic               neg2;
  int_t               mag1;
  int_t               mag2;
  int_t               divisor;
  int_t               uq;
  int_t               ur;

  // Signed division runs on magnitudes; quotient sign is the XOR of operand
  // signs, remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    neg1    = (operation == DIV) && operand1[31];
    neg2    = (operation == DIV) && operand2[31];
    mag1    = neg1 ? -operand1 : operand1;
    mag2    = neg2 ? -operand2 : operand2;
    divisor = (mag2 == '0) ? int_t'(1) : mag2;
    uq      = mag1 / divisor;
    ur      = mag1 % divisor;
    sprod   = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
    uprod   = {32'd0, operand1} * {32'd0, operand2};
  end

  always_comb begin
    result_c        = '0;
    writes_result_c = 1'b0;
    div_by_zero_c   = 1'b0;
    case (operation)
      MULT: begin
        result_c.hi     = sprod[63:32];
        result_c.lo     = sprod[31:0];
        writes_result_c = 1'b1;
      end
      MULTU: begin
        result_c.hi     = uprod[63:32];
        result_c.lo     = uprod[31:0];
        writes_result_c = 1'b1;
      end
      DIV, DIVU: begin
        result_c.lo     = (neg1 ^ neg2) ? -uq : uq;
        result_c.hi     = neg1 ? -ur : ur;
        writes_result_c = 1'b1;
        div_by_zero_c   = (operand2 == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls execution while
// a result is pending, and HI/LO commit on the last busy edge.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  int_t           operand1,
  input  int_t           operand2,
  input  mdu_operation_t operation,
  input  logic           start,
  output logic           busy,
  output int_t           dataRead
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  mdu_result_t      pending, pending_next;
  logic             pending_dbz, pending_dbz_next;
  int_t             hi, hi_next;
  int_t             lo, lo_next;

  mdu_result_t      calc_result;
  logic             calc_writes;
  logic             calc_dbz;

  mult_div_unit_result_calc u_calc (
    .operand1        (operand1),
    .operand2        (operand2),
    .operation       (operation),
    .result_c        (calc_result),
    .writes_result_c (calc_writes),
    .div_by_zero_c   (calc_dbz)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      counter     <= '0;
      pending     <= '0;
      pending_dbz <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      pending     <= pending_next;
      pending_dbz <= pending_dbz_next;
      hi          <= hi_next;
      lo          <= lo_next;
      busy        <= (state_next == ST_RUN);
    end
  end

  // Start is only honoured in IDLE; a start during RUN is dropped.
  always_comb begin
    state_next       = state;
    counter_next     = counter;
    pending_next     = pending;
    pending_dbz_next = pending_dbz;
    hi_next          = hi;
    lo_next          = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (calc_writes) begin
            pending_next     = calc_result;
            pending_dbz_next = calc_dbz;
            counter_next     = (operation == MULT || operation == MULTU) ?
                               CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_next       = ST_RUN;
          end else if (operation == MTHI) begin
            hi_next = operand1;
          end else if (operation == MTLO) begin
            lo_next = operand1;
          end
        end
      end
      ST_RUN: begin
        counter_next = counter - CNT_W'(1);
        if (counter <= CNT_W'(1)) begin
          counter_next = '0;
          state_next   = ST_IDLE;
          if (!pending_dbz) begin
            hi_next = pending.hi;
            lo_next = pending.lo;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dataRead = '0;
    if (operation == MFHI) dataRead = hi;
    else if (operation == MFLO) dataRead = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against a cycle-stamped arithmetic model of HI/LO and busy.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic           clock = 1'b0;
  logic           reset;
  int_t           operand1;
  int_t           operand2;
  mdu_operation_t operation;
  logic           start;
  logic           busy;
  int_t           dataRead;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clock     (clock),
    .reset     (reset),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .start     (start),
    .busy      (busy),
    .dataRead  (dataRead)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op is busy until cycle 'done', results land at that cycle.
  int          cyc  = 0;
  int          done = 0;
  bit          was_busy;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_valid = 0;
  longint      prod;
  int          sa, sb;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; done = 0; p_valid = 0;
    end else begin
      was_busy = (cyc < done);
      cyc++;
      if (cyc == done && p_valid) begin
        m_hi = p_hi; m_lo = p_lo; p_valid = 0;
      end
      if (!was_busy && start) begin
        case (operation)
          MULT, MULTU: begin
            if (operation == MULT) prod = longint'($signed(operand1)) * longint'($signed(operand2));
            else                   prod = longint'({32'd0, operand1}) * longint'({32'd0, operand2});
            p_hi = prod[63:32]; p_lo = prod[31:0]; p_valid = 1; done = cyc + MC;
          end
          DIV, DIVU: begin
            done = cyc + DC;
            p_valid = (operand2 != 0);
            if (operand2 != 0) begin
              if (operation == DIVU) begin
                p_lo = operand1 / operand2; p_hi = operand1 % operand2;
              end else if (operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
                p_lo = 32'h8000_0000; p_hi = 32'h0;
              end else begin
                sa = operand1; sb = operand2;
                p_lo = sa / sb; p_hi = sa % sb;
              end
            end
          end
          MTHI: m_hi = operand1;
          MTLO: m_lo = operand1;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (run_chk && !reset) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc < done)});
      check("dataRead", dataRead,
            (operation == MFHI) ? m_hi : (operation == MFLO) ? m_lo : 32'h0);
    end
  end

  task automatic issue(input mdu_operation_t op, input int_t a, input int_t b);
    @(posedge clock); #1;
    operation = op; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; operation = MDU_NONE;
  endtask

  task automatic wait_idle(output int n);
    bit idle;
    idle = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) begin idle = 1; break; end
      n++;
    end
    if (!idle) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy still %b after 100 cycles", busy);
    end
  endtask

  task automatic read_reg(input mdu_operation_t op, output int_t v);
    @(posedge clock); #1;
    operation = op;
    #1 v = dataRead;
  endtask

  function automatic int_t rnd_word();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return int_t'($urandom % 16);
      default: return int_t'($urandom);
    endcase
  endfunction

  initial begin
    int   n;
    int_t v;
    reset = 1'b1; start = 1'b0; operation = MDU_NONE; operand1 = '0; operand2 = '0;
    repeat (2) @(posedge clock);
    #1 operation = MFHI;
    #1 check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_hi", dataRead, 32'h0);
    @(posedge clock); #1 reset = 1'b0; operation = MDU_NONE; run_chk = 1;

    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n); check("mult_busy_cycles", n, MC);
    read_reg(MFHI, v); check("mult_hi", v, 32'hFFFF_FFFF);
    read_reg(MFLO, v); check("mult_lo", v, 32'hFFFF_FFFA);
    check("model_mult_lo", m_lo, 32'hFFFF_FFFA);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n); check("multu_busy_cycles", n, MC);
    read_reg(MFHI, v); check("multu_hi", v, 32'hFFFF_FFFE);
    read_reg(MFLO, v); check("multu_lo", v, 32'h0000_0001);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n); check("div_busy_cycles", n, DC);
    read_reg(MFLO, v); check("div_lo", v, 32'hFFFF_FFFD);
    read_reg(MFHI, v); check("div_hi", v, 32'hFFFF_FFFF);
    check("model_div_hi", m_hi, 32'hFFFF_FFFF);

    issue(DIVU, 32'd7, 32'd2);
    wait_idle(n);
    read_reg(MFLO, v); check("divu_lo", v, 32'd3);
    read_reg(MFHI, v); check("divu_hi", v, 32'd1);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    read_reg(MFLO, v); check("div_ovf_lo", v, 32'h8000_0000);
    read_reg(MFHI, v); check("div_ovf_hi", v, 32'h0);

    issue(MTHI, 32'h1234, 32'h0);
    wait_idle(n); check("mthi_busy_cycles", n, 0);
    issue(DIVU, 32'd55, 32'd0);
    wait_idle(n); check("divz_busy_cycles", n, DC);
    read_reg(MFHI, v); check("divz_hi_kept", v, 32'h1234);

    issue(MTLO, 32'hABCD, 32'h0);
    wait_idle(n); check("mtlo_busy_cycles", n, 0);
    read_reg(MFLO, v); check("mtlo_lo", v, 32'hABCD);

    // Start during RUN must be dropped without disturbing the pending divide.
    issue(DIVU, 32'd100, 32'd7);
    repeat (3) @(posedge clock);
    #1 operation = MULT; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
    @(posedge clock); #1 start = 1'b0; operation = MDU_NONE;
    wait_idle(n); check("midrun_busy_left", n, DC - 4);
    read_reg(MFLO, v); check("midrun_lo", v, 32'd14);
    read_reg(MFHI, v); check("midrun_hi", v, 32'd2);

    issue(MULT, 32'd9, 32'd9);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; operation = MFLO;
    #1 check("reset_midrun_busy", {31'd0, busy}, 32'h0);
    check("reset_midrun_lo", dataRead, 32'h0);
    @(posedge clock); #1 reset = 1'b0; operation = MDU_NONE;
    check("model_reset_hi", m_hi, 32'h0);
    issue(MULT, 32'd2, 32'd3);
    wait_idle(n); check("post_reset_busy_cycles", n, MC);
    read_reg(MFLO, v); check("post_reset_lo", v, 32'd6);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      operation = mdu_operation_t'(4'($urandom % 9));
      operand1  = rnd_word();
      operand2  = rnd_word();
      start     = (($urandom % 3) == 0);
    end
    #1 start = 1'b0; operation = MFLO;
    wait_idle(n);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide responder for the execution stage.
- Owns the architectural HI/LO registers.
- Accepts one-cycle start pulses with operands and an operation code from execution. Reports busy while a multiply or divide is in flight. Returns HI or LO combinationally on dataRead for move-from instructions.
- Execution treats busy as a pipeline stall, so busy timing is the contract.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- operand1  input  32  rs value (dividend / multiplicand / MTHI-MTLO source)
- operand2  input  32  rt value (divisor / multiplier)
- operation  input  mdu_operation_t  MDU_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- start  input  1  launch operation this cycle; execution already gates it with !stall
- busy  output  1  registered; high while a multiply/divide is outstanding
- dataRead  output  32  combinational: HI when operation==MFHI, LO when MFLO, else 0

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, state=IDLE; dataRead therefore reads 0 for MFHI/MFLO after reset.
- States:
  - IDLE: start sampled only here.
  - RUN: counter>0, result held in pending_hi/pending_lo.
- IDLE + start + MULT/MULTU:
  - Compute the 64-bit product at the start edge: signed for MULT, unsigned for MULTU. pending_hi = product[63:32], pending_lo = product[31:0].
  - counter = MULT_CYCLES; go to RUN.
- IDLE + start + DIV/DIVU:
  - pending_lo = quotient, pending_hi = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - counter = DIV_CYCLES; go to RUN.
- IDLE + start + MTHI/MTLO: HI (or LO) = operand1 at that edge; busy stays 0; stay IDLE.
- start with MFHI/MFLO/MDU_NONE: no state change.
- busy = (state==RUN), registered.
  - It rises the cycle after the start edge and stays high exactly N cycles.
  - The HI/LO commit happens at the edge where counter 1->0. busy is low from the next cycle and HI/LO are new simultaneously.
- In RUN, decrement counter each edge; start is ignored (illegal by protocol; assert in simulation).
- dataRead is purely combinational from committed HI/LO, never pending values. Forwarding HI/LO around in-flight ops is unnecessary because execution stalls while busy.
- Divide by zero (operand2==0, DIV or DIVU): full DIV_CYCLES busy, then HI/LO unchanged.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0; no trap.
- Reset asserted mid-RUN: busy drops immediately (async), pending result discarded, HI/LO=0.
- Back-to-back: a start is accepted the first cycle busy is low, i.e. the cycle after commit.

Decomposition:
- Shared definitions package (`Definitions.sv`): mdu_operation_t enum, int_t, the MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module mdu_result_calc (combinational): operands + operation -> {hi, lo, writes_result, div_by_zero}. Keeps signed/unsigned arithmetic and the corner-case rules isolated and unit-testable.
- Top holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- MULT: 0xFFFFFFFE * 3, start 1 cycle -> busy high cycles 1..5. At cycle 6, MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA.
- MULTU: 0xFFFFFFFF * 0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- DIV: -7 / 2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU: 7 / 2 -> LO=3, HI=1.
- Corner cases: DIV 0x80000000 / -1 -> LO=0x80000000, HI=0. MTHI 0x1234 then DIVU x / 0 -> busy 10 cycles, HI still 0x1234.
- MTLO 0xABCD with start -> busy never rises; next cycle MFLO=0xABCD. A start asserted mid-RUN is ignored and the pending result is unaffected.
- Reset at busy cycle 3 of a MULT -> busy=0 same cycle, HI=LO=0. A fresh MULT 2*3 then completes normally with LO=6.
